// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the load/store execution stage: opcodes, response
// error codes and the access FSM state encoding.
package dmem_access_unit_pkg;

  localparam logic [5:0] OP_LW = 6'd8;
  localparam logic [5:0] OP_SW = 6'd9;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  function automatic logic is_store_op(input logic [5:0] opcode);
    return opcode == OP_SW;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Bundle of the processor request, data-memory port and writeback response
// signals around the load/store unit.
interface dmem_access_unit_if
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd_idx;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  logic              resp_valid;
  logic              resp_load;
  logic [4:0]        resp_rd_idx;
  logic [31:0]       resp_data;
  err_e              resp_err;
  logic              busy;

  // The unit itself.
  modport slave (
    input  req_valid, req_store, req_addr, req_wdata, req_rd_idx,
    input  mem_ready, mem_rdata,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
    output resp_valid, resp_load, resp_rd_idx, resp_data, resp_err, busy
  );

  // Processor pipeline plus data memory.
  modport master (
    output req_valid, req_store, req_addr, req_wdata, req_rd_idx,
    output mem_ready, mem_rdata,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
    input  resp_valid, resp_load, resp_rd_idx, resp_data, resp_err, busy
  );
endinterface

// File: rtl/dmem_addr_check.sv
// Converts a byte address to a data-memory word address and flags
// misalignment (highest priority) or an address beyond the memory.
module dmem_addr_check
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [31:0]       byte_addr,
  output logic [ADDR_W-1:0] word_addr,
  output err_e              err
);

  assign word_addr = byte_addr[ADDR_W+1:2];

  always_comb begin
    if (byte_addr[1:0] != 2'b00) begin
      err = ERR_ALIGN;
    end else if ((byte_addr >> (ADDR_W + 2)) != 32'd0) begin
      err = ERR_RANGE;
    end else begin
      err = ERR_OK;
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store stage: validates the computed address, runs one handshaked
// data-memory access with a timeout, and returns a one-cycle response.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  dmem_access_unit_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [4:0]        rd_idx_q, rd_idx_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_load_q, resp_load_d;
  logic [4:0]        resp_rd_idx_q, resp_rd_idx_d;
  logic [31:0]       resp_data_q, resp_data_d;
  err_e              resp_err_q, resp_err_d;

  logic [ADDR_W-1:0] chk_word_addr;
  err_e              chk_err;

  dmem_addr_check #(
    .ADDR_W(ADDR_W)
  ) u_addr_check (
    .byte_addr(bus.req_addr),
    .word_addr(chk_word_addr),
    .err      (chk_err)
  );

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    store_d       = store_q;
    rd_idx_d      = rd_idx_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    resp_valid_d  = 1'b0;
    resp_load_d   = 1'b0;
    resp_rd_idx_d = 5'd0;
    resp_data_d   = 32'd0;
    resp_err_d    = ERR_OK;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          store_d     = bus.req_store;
          rd_idx_d    = bus.req_rd_idx;
          mem_addr_d  = chk_word_addr;
          mem_wdata_d = bus.req_wdata;
          if (chk_err != ERR_OK) begin
            // Rejected requests never reach the memory port.
            state_d       = S_RESP;
            resp_valid_d  = 1'b1;
            resp_load_d   = !bus.req_store;
            resp_rd_idx_d = bus.req_store ? 5'd0 : bus.req_rd_idx;
            resp_err_d    = chk_err;
          end else begin
            state_d  = S_ACCESS;
            cnt_d    = CNT_W'(1);
            mem_en_d = 1'b1;
            mem_we_d = bus.req_store;
          end
        end
      end

      S_ACCESS: begin
        resp_load_d   = !store_q;
        resp_rd_idx_d = store_q ? 5'd0 : rd_idx_q;
        if (bus.mem_ready) begin
          // A completion on the final allowed cycle still counts as success.
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = store_q ? 32'd0 : bus.mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_TIMEOUT;
        end else begin
          resp_load_d   = 1'b0;
          resp_rd_idx_d = 5'd0;
          cnt_d         = cnt_q + CNT_W'(1);
          mem_en_d      = 1'b1;
          mem_we_d      = store_q;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      store_q       <= 1'b0;
      rd_idx_q      <= 5'd0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_load_q   <= 1'b0;
      resp_rd_idx_q <= 5'd0;
      resp_data_q   <= 32'd0;
      resp_err_q    <= ERR_OK;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      store_q       <= store_d;
      rd_idx_q      <= rd_idx_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_load_q   <= resp_load_d;
      resp_rd_idx_q <= resp_rd_idx_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE) && !rst;
  assign bus.busy        = (state_q != S_IDLE) && !rst;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_load   = resp_load_q;
  assign bus.resp_rd_idx = resp_rd_idx_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus random
// requests checked against a transaction-level latency/result model.
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_access_unit #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Error code a request should receive, from the memory geometry alone.
  function automatic int ref_err(input logic [31:0] addr);
    if (addr % 4 != 0) return 1;
    if (longint'(addr) >= (longint'(4) << ADDR_W)) return 2;
    return 0;
  endfunction

  // Issue one request, play memory with mem_ready on ACCESS cycle 'delay'
  // (0 = never), and check the whole transaction against the model.
  task automatic run_op(input logic [5:0] opcode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input int delay, input logic [31:0] rdata,
                        input string tag);
    logic store;
    int e_err, e_en, e_cyc;
    logic [31:0] e_data;
    logic [4:0] e_rd;
    logic [ADDR_W-1:0] e_waddr;
    int en_cnt, got_cyc, w;
    bit bus_bad, busy_bad;
    int r_err;
    logic [31:0] r_data;
    logic [4:0] r_rd;
    logic r_load;

    store   = is_store_op(opcode);
    e_err   = ref_err(addr);
    e_waddr = ADDR_W'(addr / 4);
    if (e_err != 0) begin
      e_en = 0; e_cyc = 1;
    end else if (delay >= 1 && delay <= TIMEOUT) begin
      e_en = delay; e_cyc = delay + 1;
    end else begin
      e_en = TIMEOUT; e_cyc = TIMEOUT + 1; e_err = 3;
    end
    e_data = (e_err == 0 && !store) ? rdata : 32'd0;
    e_rd   = store ? 5'd0 : rd;

    w = 0;
    while (!bus.req_ready && w < 5) begin
      step();
      w++;
    end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s req_ready: got %b want 1", tag, bus.req_ready);
    end

    bus.req_valid  = 1'b1;
    bus.req_store  = store;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd_idx = rd;
    bus.mem_ready  = 1'($urandom_range(0, 1));
    bus.mem_rdata  = $urandom;
    step();
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'($urandom_range(0, 1));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_rd_idx = 5'($urandom);

    en_cnt = 0; got_cyc = 0; bus_bad = 0; busy_bad = 0;
    r_err = 0; r_data = '0; r_rd = '0; r_load = 1'b0;
    for (int k = 1; k <= TIMEOUT + 4 && got_cyc == 0; k++) begin
      if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) busy_bad = 1;
      if (bus.mem_en === 1'b1) begin
        en_cnt++;
        if (bus.mem_addr !== e_waddr || bus.mem_we !== store) bus_bad = 1;
        if (store && bus.mem_wdata !== wdata) bus_bad = 1;
      end
      if (bus.resp_valid === 1'b1) begin
        got_cyc = k;
        r_err   = int'(bus.resp_err);
        r_data  = bus.resp_data;
        r_rd    = bus.resp_rd_idx;
        r_load  = bus.resp_load;
        bus.mem_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.mem_ready = (k == delay);
        bus.mem_rdata = (k == delay) ? rdata : $urandom;
      end
      step();
    end

    n_cmp++;
    if (got_cyc != e_cyc) begin
      n_bad++;
      $display("FAIL %s resp_cycle: got %0d want %0d", tag, got_cyc, e_cyc);
    end
    n_cmp++;
    if (en_cnt != e_en) begin
      n_bad++;
      $display("FAIL %s mem_en_cycles: got %0d want %0d", tag, en_cnt, e_en);
    end
    n_cmp++;
    if (bus_bad) begin
      n_bad++;
      $display("FAIL %s mem_bus: addr/we/wdata got %h/%b/%h want %h/%b/%h",
               tag, bus.mem_addr, bus.mem_we, bus.mem_wdata, e_waddr, store, wdata);
    end
    n_cmp++;
    if (busy_bad) begin
      n_bad++;
      $display("FAIL %s busy_ready: busy=%b req_ready=%b want busy 1 req_ready 0",
               tag, bus.busy, bus.req_ready);
    end
    n_cmp++;
    if (r_err != e_err || r_data !== e_data || r_rd !== e_rd || r_load !== !store) begin
      n_bad++;
      $display("FAIL %s resp: err/data/rd/load got %0d/%h/%0d/%b want %0d/%h/%0d/%b",
               tag, r_err, r_data, r_rd, r_load, e_err, e_data, e_rd, !store);
    end
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'd0 || bus.resp_rd_idx !== 5'd0 ||
        bus.resp_load !== 1'b0 || bus.resp_err !== ERR_OK || bus.mem_en !== 1'b0 ||
        bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s after_resp: valid=%b err=%0d data=%h en=%b busy=%b ready=%b want idle/zero",
               tag, bus.resp_valid, bus.resp_err, bus.resp_data, bus.mem_en, bus.busy,
               bus.req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== 32'd0 || bus.resp_valid !== 1'b0 || bus.resp_load !== 1'b0 ||
        bus.resp_rd_idx !== 5'd0 || bus.resp_data !== 32'd0 || bus.resp_err !== ERR_OK ||
        bus.req_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: en=%b addr=%h valid=%b ready=%b busy=%b want all 0",
               bus.mem_en, bus.mem_addr, bus.resp_valid, bus.req_ready, bus.busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b busy=%b want 1/0", bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_store_fast();
    run_op(OP_SW, 32'h40, 32'hDEADBEEF, 5'd3, 1, 32'h0, "sw_fast");
  endtask

  task automatic test_load_wait();
    run_op(OP_LW, 32'h44, 32'h0, 5'd7, 3, 32'h12345678, "lw_wait3");
  endtask

  task automatic test_misaligned();
    run_op(OP_LW, 32'h42, 32'h0, 5'd4, 1, 32'hCAFEF00D, "lw_misaligned");
    run_op(OP_LW, 32'h1002, 32'h0, 5'd5, 1, 32'hCAFEF00D, "lw_both_faults");
  endtask

  task automatic test_range();
    run_op(OP_SW, 32'h1000, 32'h11112222, 5'd1, 1, 32'h0, "sw_out_of_range");
    run_op(OP_SW, 32'hFFC, 32'h33334444, 5'd1, 1, 32'h0, "sw_last_word");
  endtask

  task automatic test_timeout();
    run_op(OP_LW, 32'h8, 32'h0, 5'd9, 0, 32'h55AA55AA, "lw_timeout");
    run_op(OP_LW, 32'h8, 32'h0, 5'd9, TIMEOUT, 32'h55AA55AA, "lw_ready_at_limit");
    run_op(OP_LW, 32'h8, 32'h0, 5'd9, TIMEOUT + 1, 32'h55AA55AA, "lw_ready_too_late");
  endtask

  task automatic test_reset_mid();
    bit saw_resp;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_addr   = 32'h20;
    bus.req_rd_idx = 5'd12;
    bus.mem_ready  = 1'b0;
    step();
    bus.req_valid = 1'b0;
    saw_resp = bus.resp_valid;
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_during: busy=%b ready=%b want 0/0", bus.busy, bus.req_ready);
    end
    step();
    n_cmp++;
    if (bus.mem_en !== 1'b0 || bus.resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_after: en=%b valid=%b want 0/0", bus.mem_en, bus.resp_valid);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.resp_valid === 1'b1) saw_resp = 1'b1;
      if (k < 3) step();
    end
    bus.mem_ready = 1'b0;
    n_cmp++;
    if (saw_resp || bus.req_ready !== 1'b1 || bus.mem_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_dropped: saw_resp=%b ready=%b en=%b want 0/1/0",
               saw_resp, bus.req_ready, bus.mem_en);
    end
    run_op(OP_LW, 32'h24, 32'h0, 5'd13, 2, 32'hA5A5F00F, "lw_after_rst");
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    logic [31:0] addr;
    int kind, delay;
    for (int i = 0; i < 40; i++) begin
      op   = ($urandom_range(0, 1) == 1) ? OP_SW : OP_LW;
      kind = $urandom_range(0, 9);
      if (kind < 6)      addr = 32'($urandom_range(0, (1 << ADDR_W) - 1)) * 4;
      else if (kind < 8) addr = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else               addr = ((1 << (ADDR_W + 2)) + $urandom) & 32'hFFFF_FFFC;
      delay = $urandom_range(0, TIMEOUT + 2);
      run_op(op, addr, $urandom, 5'($urandom), delay, $urandom, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_rd_idx = 5'd0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 32'd0;

    test_reset();
    test_store_fast();
    test_load_wait();
    test_misaligned();
    test_range();
    test_timeout();
    test_reset_mid();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
